// File: rtl/rr_grant_hold_pkg.sv
// Shared types and elaboration helpers for the rr_grant_hold round-robin arbiter.
package rr_grant_hold_pkg;

    // Arbiter FSM: no grant outstanding, or one requester owns the grant.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Width of a binary index over n requesters; never less than one bit
    // so a single-requester build still has a legal index/pointer port.
    function automatic int idx_width(input int n);
        int w;
        if (n > 1) begin
            w = $clog2(n);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage : rr_grant_hold_pkg

// File: rtl/leave_one_hot.sv
// Isolates the lowest set bit of a vector (x & -x); all-zero in gives all-zero out.
module leave_one_hot #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [WIDTH-1:0] o_vec
);

    logic [WIDTH-1:0] w_neg;

    // Two's complement negation; ANDing with the original keeps only the lowest 1.
    assign w_neg = ~i_vec + {{(WIDTH-1){1'b0}}, 1'b1};
    assign o_vec = i_vec & w_neg;

endmodule : leave_one_hot

// File: rtl/rr_grant_hold.sv
// Round-robin arbiter with grant hold. A registered one-hot grant is issued
// one cycle after a request is seen and is held until the owner releases it
// (or drops its request). On release the next requester after the owner in
// circular order is granted back-to-back, so consumers see a glitch-free,
// strictly one-hot select.
module rr_grant_hold
    import rr_grant_hold_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int IDX_W = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_ena,
    input  logic [WIDTH-1:0] i_req,
    input  logic             i_release,
    output logic [WIDTH-1:0] o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_busy
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [WIDTH-1:0] r_grant;
    logic [IDX_W-1:0] r_grant_idx;
    logic             r_busy;

    // ------------------------------------------------------------------
    // Combinational pick path
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_ptr_next;   // position just after the current owner
    logic [IDX_W-1:0] w_ptr_eff;    // start of the search for this cycle's pick
    logic [WIDTH-1:0] w_mask;       // bits at or above w_ptr_eff
    logic [WIDTH-1:0] w_hi;         // requests in the upper (higher priority) window
    logic [WIDTH-1:0] w_hi_one;
    logic [WIDTH-1:0] w_all_one;
    logic [WIDTH-1:0] w_pick;
    logic             w_req_any;
    logic             w_end;        // owner is done: explicit release or request dropped

    // One-hot to binary; bits are ORed so no priority chain is implied.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [WIDTH-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                idx = idx | IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Pointer successor of the current owner, wrapping the last requester to 0.
    always_comb begin
        w_ptr_next = '0;
        if (r_grant_idx == IDX_W'(WIDTH - 1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = r_grant_idx + IDX_W'(1);
        end
    end

    // While a grant is held the successor pick must start after the owner,
    // even though r_ptr is only updated on the same edge as the new grant.
    always_comb begin
        w_ptr_eff = r_ptr;
        if (r_state == ST_GRANT) begin
            w_ptr_eff = w_ptr_next;
        end else begin
            w_ptr_eff = r_ptr;
        end
    end

    // Thermometer mask selecting requesters at or above the search start.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (IDX_W'(i) >= w_ptr_eff) begin
                w_mask[i] = 1'b1;
            end else begin
                w_mask[i] = 1'b0;
            end
        end
    end

    assign w_hi      = i_req & w_mask;
    assign w_req_any = |i_req;

    leave_one_hot #(.WIDTH(WIDTH)) u_pick_hi (
        .i_vec (w_hi),
        .o_vec (w_hi_one)
    );

    leave_one_hot #(.WIDTH(WIDTH)) u_pick_all (
        .i_vec (i_req),
        .o_vec (w_all_one)
    );

    // Upper window wins; otherwise wrap around to the lowest requester overall.
    always_comb begin
        w_pick = '0;
        if (w_hi != '0) begin
            w_pick = w_hi_one;
        end else begin
            w_pick = w_all_one;
        end
    end

    // Owner finished: explicit release, or its request vanished (abort).
    always_comb begin
        w_end = 1'b0;
        if (r_state == ST_GRANT) begin
            w_end = i_release | ~i_req[r_grant_idx];
        end else begin
            w_end = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FSM, pointer and registered outputs
    // ------------------------------------------------------------------

    // Arbitration state machine; everything freezes while i_ena is low.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_busy      <= 1'b0;
        end else if (i_ena) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_any) begin
                        r_state     <= ST_GRANT;
                        r_grant     <= w_pick;
                        r_grant_idx <= onehot_to_idx(w_pick);
                        r_busy      <= 1'b1;
                    end else begin
                        r_state     <= ST_IDLE;
                        r_grant     <= '0;
                        r_grant_idx <= '0;
                        r_busy      <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (w_end) begin
                        r_ptr <= w_ptr_next;
                        if (w_req_any) begin
                            // Hand over without an idle bubble; a sole owner
                            // still requesting is re-granted via the wrap.
                            r_state     <= ST_GRANT;
                            r_grant     <= w_pick;
                            r_grant_idx <= onehot_to_idx(w_pick);
                            r_busy      <= 1'b1;
                        end else begin
                            r_state     <= ST_IDLE;
                            r_grant     <= '0;
                            r_grant_idx <= '0;
                            r_busy      <= 1'b0;
                        end
                    end else begin
                        // Owner keeps the grant; other request changes ignored.
                        r_state     <= ST_GRANT;
                        r_ptr       <= r_ptr;
                        r_grant     <= r_grant;
                        r_grant_idx <= r_grant_idx;
                        r_busy      <= r_busy;
                    end
                end
                default: begin
                    // Unreachable encoding: return to a safe idle state.
                    r_state     <= ST_IDLE;
                    r_ptr       <= '0;
                    r_grant     <= '0;
                    r_grant_idx <= '0;
                    r_busy      <= 1'b0;
                end
            endcase
        end else begin
            r_state     <= r_state;
            r_ptr       <= r_ptr;
            r_grant     <= r_grant;
            r_grant_idx <= r_grant_idx;
            r_busy      <= r_busy;
        end
    end

    assign o_grant     = r_grant;
    assign o_grant_idx = r_grant_idx;
    assign o_busy      = r_busy;

endmodule : rr_grant_hold

// File: tb/tb_rr_grant_hold.sv
// Directed and randomised check of rr_grant_hold with WIDTH=8.
module tb_rr_grant_hold;

    localparam int WIDTH = 8;
    localparam int IDX_W = 3;

    logic             clk;
    logic             nrst;
    logic             ena;
    logic [WIDTH-1:0] req;
    logic             rel;
    logic [WIDTH-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             busy;

    int n_tests;
    int n_fail;

    rr_grant_hold #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .i_ena       (ena),
        .i_req       (req),
        .i_release   (rel),
        .o_grant     (grant),
        .o_grant_idx (grant_idx),
        .o_busy      (busy)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] eg, input logic [2:0] ei, input logic eb);
        chk({tag, ".grant"}, 32'(grant), 32'(eg));
        chk({tag, ".idx"}, 32'(grant_idx), 32'(ei));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_g;
    int         waitcnt [WIDTH];
    int         max_wait;
    logic       prev_busy;
    logic       ev;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        nrst = 1'b0;
        ena  = 1'b1;
        req  = 8'hFF;
        rel  = 1'b0;

        // Reset holds outputs low despite pending requests.
        #12;
        chk_out("reset", 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        nrst = 1'b1;
        step();
        chk_out("first_grant", 8'h01, 3'd0, 1'b1);

        // Rotation with a release every cycle, including the wrap 80 -> 01.
        rel = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            exp_g = 8'h01 << ((k + 1) % 8);
            chk("rotate", 32'(grant), 32'(exp_g));
        end
        rel = 1'b0;
        step();
        chk_out("rotate_hold", 8'h01, 3'd0, 1'b1);

        // Move the grant to requester 2.
        rel = 1'b1;
        step();
        chk("to_02", 32'(grant), 32'h02);
        step();
        chk_out("to_04", 8'h04, 3'd2, 1'b1);
        rel = 1'b0;

        // Hold: other bits toggle, no release.
        for (int k = 0; k < 20; k++) begin
            req = (k % 2 == 1) ? 8'h85 : 8'h04;
            step();
            chk_out("hold", 8'h04, 3'd2, 1'b1);
        end

        // Advance to requester 4.
        req = 8'hFF;
        rel = 1'b1;
        step();
        chk("to_08", 32'(grant), 32'h08);
        step();
        chk_out("to_10", 8'h10, 3'd4, 1'b1);

        // Abort: owner drops its request, search wraps past 5..7.
        rel = 1'b0;
        req = 8'h03;
        step();
        chk_out("abort", 8'h01, 3'd0, 1'b1);

        // Sole requester 5 re-granted after its own release.
        req = 8'h20;
        rel = 1'b1;
        step();
        chk_out("sole_first", 8'h20, 3'd5, 1'b1);
        step();
        chk_out("sole_regrant", 8'h20, 3'd5, 1'b1);

        // No requests left: go idle.
        req = 8'h00;
        step();
        chk_out("to_idle", 8'h00, 3'd0, 1'b0);
        // Release while idle is ignored.
        step();
        chk_out("idle_release", 8'h00, 3'd0, 1'b0);

        // Pointer was left at 6, so requester 6 wins from idle.
        rel = 1'b0;
        req = 8'hFF;
        step();
        chk_out("ptr_from_idle", 8'h40, 3'd6, 1'b1);

        // Clock enable low: release pulse is lost.
        ena = 1'b0;
        rel = 1'b1;
        step();
        chk_out("ena_freeze", 8'h40, 3'd6, 1'b1);
        ena = 1'b1;
        rel = 1'b0;
        step();
        chk_out("ena_lost_rel", 8'h40, 3'd6, 1'b1);

        // Asynchronous reset mid-grant, observed before any clock edge.
        @(negedge clk);
        nrst = 1'b0;
        #1;
        chk_out("async_reset", 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        nrst = 1'b1;
        step();
        chk_out("post_reset", 8'h01, 3'd0, 1'b1);

        // Random phase: sticky requests, random releases; check invariants
        // and that no waiting requester is passed over more than WIDTH times.
        for (int i = 0; i < WIDTH; i++) waitcnt[i] = 0;
        max_wait = 0;
        for (int c = 0; c < 3000; c++) begin
            rel = 1'b0;
            if (busy && ($urandom_range(0, 2) == 0)) begin
                rel = 1'b1;
                if ($urandom_range(0, 1) == 0) req[grant_idx] = 1'b0;
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (!req[i] && ($urandom_range(0, 3) == 0)) req[i] = 1'b1;
            end
            prev_busy = busy;
            step();
            chk("onehot0", 32'($onehot0(grant)), 32'd1);
            chk("busy_or", 32'(busy), 32'(|grant));
            chk("idx_bit", 32'(grant[grant_idx]), 32'(busy));
            ev = (!prev_busy && busy) || (prev_busy && rel && busy);
            for (int i = 0; i < WIDTH; i++) begin
                if (!req[i]) begin
                    waitcnt[i] = 0;
                end else if (ev && (i == int'(grant_idx))) begin
                    waitcnt[i] = 0;
                end else if (ev) begin
                    waitcnt[i]++;
                    if (waitcnt[i] > max_wait) max_wait = waitcnt[i];
                end
            end
        end
        chk("starve", 32'(max_wait <= WIDTH), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rr_grant_hold
